// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues word-aligned fetch requests to the
// instruction memory, collects the in-order responses into a small queue
// with their PCs, and presents the queue head to the IF/ID register. A
// redirect from execute flushes the queue, restarts fetching at the target,
// and discards every response still owed for the abandoned path.
//
// Parameters
//   RESET_PC : address of the first fetch after reset
//   DEPTH    : instruction queue entries (power of two, >= 2)
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   imem_req_valid : fetch request valid (combinational)
//   imem_req_addr  : fetch address (current fetch_pc)
//   imem_req_ready : memory accepts the request this cycle
//   imem_rsp_valid : instruction word returned (in request order)
//   imem_rsp_data  : returned instruction word
//   redirect_valid : taken branch / jal / jalr from execute
//   redirect_pc    : redirect target (low two bits ignored)
//   out_valid      : queue head valid
//   out_ready      : decode accepts the head
//   out_pc         : PC of the head (fetch_pc when empty)
//   out_instr      : head instruction (NOP when empty)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic          req_accept;
    logic          rsp_take;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [CW:0]   in_flight;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_target;

    // A new request is only issued when the queue is guaranteed to have room
    // for its response, so responses never need backpressure.
    assign in_flight      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = rst && !redirect_valid && (in_flight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_accept = imem_req_valid && imem_req_ready;
    assign rsp_take   = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop   = rsp_take && (drop_cnt != '0);
    assign push       = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign pop        = out_valid && out_ready;

    // Once all stale responses are gone, every outstanding request belongs
    // to the current sequential path, so the oldest one (the one answering
    // now) was issued at fetch_pc minus four per outstanding request.
    assign rsp_pc          = fetch_pc - {{(32-CW-2){1'b0}}, outstanding, 2'b00};
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? pc_q[head]    : fetch_pc;
    assign out_instr = out_valid ? instr_q[head] : NOP;

    // Control state. On a redirect, outstanding already includes requests
    // that are still owed for older redirects, so reloading drop_cnt from
    // outstanding keeps those older drops and adds the new ones. A response
    // arriving in the redirect cycle itself is consumed and discarded there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_accept) - CW'(rsp_take);
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                drop_cnt <= outstanding - CW'(rsp_take);
            end else begin
                if (req_accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // Queue storage needs no reset: entries are only visible through count.
    // Writing at the tail while popping a full queue is safe because the
    // head entry is read combinationally before the edge.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]    <= rsp_pc;
            instr_q[tail] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A small in-order memory model answers requests after
// a programmable latency with instruction = ~address. Every accepted request
// pushes its PC onto an expected queue; a redirect clears that queue and
// marks pending memory replies stale. Each cycle the head, the request
// handshake and the fetch address are compared against the model. Directed
// sequences cover fill latency, backpressure, redirect drops, push+pop at
// high occupancy, address wrap and mid-run reset; a table of randomised
// segments follows.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          t;
        bit          stale;
    } pend_t;

    typedef struct {
        int cycles;
        int rdy_mode;
        int lat;
        int out_mode;
        int redir_per;
        int exp_acc;
    } seg_t;

    int          errors = 0;
    int          checks = 0;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc = 0;
    bit          req_rdy = 1'b0;
    bit          out_rdy = 1'b0;
    bit          redir = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    bit          last_ov;
    bit          last_rv;
    logic [31:0] last_pc;
    logic [31:0] last_addr;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int exp_cnt, input bit exp_rv);
        check1("req_valid", imem_req_valid, exp_rv);
        check32("req_addr", imem_req_addr, model_pc);
        check1("out_valid", out_valid, exp_cnt > 0);
        if (exp_cnt > 0) begin
            check32("out_pc", out_pc, exp_q[0]);
            check32("out_instr", out_instr, ~exp_q[0]);
        end else begin
            check32("empty_pc", out_pc, model_pc);
            check32("empty_instr", out_instr, NOP);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, check the
    // settled outputs, then advance the model to match the coming edge.
    task automatic applyStimulus();
        bit rsp_now;
        int live;
        int exp_cnt;
        bit exp_rv;
        bit acc;
        bit pop;
        rsp_now = (pend.size() > 0) && (cyc >= pend[0].t + lat);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? ~pend[0].addr : 32'h0;
        imem_req_ready = req_rdy;
        out_ready      = out_rdy;
        redirect_valid = redir;
        redirect_pc    = redir_tgt;
        #1;
        live = 0;
        foreach (pend[i]) if (!pend[i].stale) live++;
        exp_cnt = exp_q.size() - live;
        exp_rv  = !redir && ((exp_cnt + pend.size()) < DEPTH);
        checkOutput(exp_cnt, exp_rv);
        last_ov   = out_valid;
        last_rv   = imem_req_valid;
        last_pc   = out_pc;
        last_addr = imem_req_addr;
        acc = exp_rv && req_rdy;
        pop = (exp_cnt > 0) && out_rdy;
        if (pop) void'(exp_q.pop_front());
        if (rsp_now) void'(pend.pop_front());
        if (redir) begin
            exp_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            model_pc = redir_tgt & 32'hFFFF_FFFC;
        end
        if (acc) begin
            pend.push_back('{addr: model_pc, t: cyc, stale: 1'b0});
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
            n_acc++;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse; a junk response is driven while in reset.
    task automatic doReset();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check32("rst_out_pc", out_pc, RESET_PC);
        check32("rst_out_instr", out_instr, NOP);
        pend.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        redir = 1'b0;
        @(negedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        req_rdy = 1'b0;
        out_rdy = 1'b1;
        redir   = 1'b0;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < 60) begin
            applyStimulus();
            n++;
        end
        checkInt({name, "_drain_left"}, pend.size() + exp_q.size(), 0);
    endtask

    task automatic waitFirstOut(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        last_ov = 1'b0;
        while (!last_ov && n < 30) begin
            applyStimulus();
            n++;
        end
        check1({name, "_seen"}, last_ov, 1'b1);
        check32({name, "_pc"}, last_pc, exp_pc);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          ov_log [6];
        logic [31:0] pc_log [6];
        seg_t        tbl [6];

        tbl[0] = '{cycles: 8,  rdy_mode: 1, lat: 1, out_mode: 1, redir_per: 0, exp_acc: 8};
        tbl[1] = '{cycles: 10, rdy_mode: 0, lat: 1, out_mode: 1, redir_per: 0, exp_acc: 0};
        tbl[2] = '{cycles: 40, rdy_mode: 2, lat: 2, out_mode: 2, redir_per: 0, exp_acc: -1};
        tbl[3] = '{cycles: 60, rdy_mode: 2, lat: 3, out_mode: 2, redir_per: 6, exp_acc: -1};
        tbl[4] = '{cycles: 60, rdy_mode: 1, lat: 5, out_mode: 2, redir_per: 4, exp_acc: -1};
        tbl[5] = '{cycles: 60, rdy_mode: 2, lat: 1, out_mode: 1, redir_per: 9, exp_acc: -1};

        @(negedge clk);
        doReset();

        // Zero-wait streaming: two-cycle fill then one word per cycle.
        req_rdy = 1'b1; out_rdy = 1'b1; lat = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            ov_log[i] = last_ov;
            pc_log[i] = last_pc;
        end
        check1("fill_c0", ov_log[0], 1'b0);
        check1("fill_c1", ov_log[1], 1'b0);
        check1("fill_c2", ov_log[2], 1'b1);
        check32("stream0", pc_log[2], 32'h0);
        check32("stream1", pc_log[3], 32'h4);
        check32("stream2", pc_log[4], 32'h8);
        check32("stream3", pc_log[5], 32'hC);

        // Decode stalled: exactly DEPTH requests, then one per pop.
        doReset();
        out_rdy = 1'b0; req_rdy = 1'b1; lat = 1; n_acc = 0;
        for (int i = 0; i < 8; i++) applyStimulus();
        checkInt("stall_accepts", n_acc, DEPTH);
        check1("stall_req_low", last_rv, 1'b0);
        out_rdy = 1'b1;
        applyStimulus();
        out_rdy = 1'b0; n_acc = 0;
        for (int i = 0; i < 6; i++) applyStimulus();
        checkInt("one_pop_one_req", n_acc, 1);

        // Redirect with two requests outstanding.
        doReset();
        out_rdy = 1'b0; req_rdy = 1'b1; lat = 6;
        applyStimulus();
        applyStimulus();
        redir = 1'b1; redir_tgt = 32'h0000_0103;
        applyStimulus();
        redir = 1'b0; lat = 1; out_rdy = 1'b1;
        applyStimulus();
        check32("redir_addr", last_addr, 32'h0000_0100);
        check1("redir_req", last_rv, 1'b1);
        waitFirstOut("redir_first", 32'h0000_0100);
        drain("redir");

        // Three queued, one response arriving while the head pops.
        doReset();
        lat = 3; out_rdy = 1'b0; req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        req_rdy = 1'b0;
        applyStimulus();
        applyStimulus();
        out_rdy = 1'b1;
        applyStimulus();
        check1("pp_req_low", last_rv, 1'b0);
        check32("pp_head0", last_pc, 32'h0);
        applyStimulus();
        check1("pp_req_high", last_rv, 1'b1);
        check32("pp_head1", last_pc, 32'h4);
        applyStimulus();
        check32("pp_head2", last_pc, 32'h8);
        applyStimulus();
        check32("pp_head3", last_pc, 32'hC);
        drain("pp");

        // Fetch address wraps at the top of the address space.
        doReset();
        lat = 1; out_rdy = 1'b1; req_rdy = 1'b1;
        redir = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        applyStimulus();
        redir = 1'b0;
        applyStimulus();
        check32("wrap_a", last_addr, 32'hFFFF_FFF8);
        applyStimulus();
        check32("wrap_b", last_addr, 32'hFFFF_FFFC);
        applyStimulus();
        check32("wrap_c", last_addr, 32'h0000_0000);
        drain("wrap");

        // Reset with three queued and one outstanding.
        doReset();
        lat = 2; out_rdy = 1'b0; req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        req_rdy = 1'b0;
        applyStimulus();
        check32("pre_reset_head", out_pc, 32'h0);
        doReset();
        lat = 1; out_rdy = 1'b1; req_rdy = 1'b1;
        waitFirstOut("post_reset", RESET_PC);
        drain("post_reset");

        // Randomised segments.
        for (int s = 0; s < 6; s++) begin
            lat = tbl[s].lat;
            n_acc = 0;
            for (int c = 0; c < tbl[s].cycles; c++) begin
                req_rdy = (tbl[s].rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (tbl[s].rdy_mode != 0);
                out_rdy = (tbl[s].out_mode == 2) ? 1'($urandom_range(0, 1)) : (tbl[s].out_mode != 0);
                redir   = (tbl[s].redir_per > 0) && ($urandom_range(0, tbl[s].redir_per - 1) == 0);
                redir_tgt = $urandom;
                applyStimulus();
            end
            if (tbl[s].exp_acc >= 0) checkInt($sformatf("seg%0d_accepts", s), n_acc, tbl[s].exp_acc);
            drain($sformatf("seg%0d", s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
